// File: rtl/arb_pkg.sv
// Types and constants shared by the requester client and the 3-port arbiter.
package arb_pkg;

    typedef enum logic [0:0] {
        IDLE,
        ACTIVE
    } state_e;

    // Port one-hot grant vectors, the same encoding the arbiter uses
    localparam logic [2:0] NONE  = 3'b000;
    localparam logic [2:0] PORT0 = 3'b001;
    localparam logic [2:0] PORT1 = 3'b010;
    localparam logic [2:0] PORT2 = 3'b100;

endpackage

// File: rtl/arb_cmd_fifo.sv
// Burst command queue: DEPTH entries of {len, data}, power-of-two depth so the
// pointers wrap for free.
module arb_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 12,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = count == CNT_W'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push & ~full;
    // An entry written at this edge is not yet counted, so it can never be popped with it
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/arb_requester.sv
// Requester-side arbiter client: queues burst commands, holds req until every beat
// is granted, and emits one beat strobe per granted cycle.
module arb_requester
    import arb_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned LEN_W  = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned STARVE = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic              pause,
    output logic              req,
    output logic              en,
    input  logic              grant,
    output logic              beat_valid,
    output logic [DATA_W-1:0] beat_data,
    output logic              beat_last,
    output logic              busy,
    output logic              starve,
    output logic              err
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned STV_W = $clog2(STARVE + 1);
    localparam int unsigned FIFO_W = LEN_W + DATA_W;

    state_e              state;
    logic [LEN_W-1:0]    beats_left;
    logic [LEN_W-1:0]    idx;
    logic [DATA_W-1:0]   base;
    logic [STV_W-1:0]    starve_cnt;

    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;
    logic [FIFO_W-1:0]   fifo_rdata;
    logic                granted;
    logic                last_beat;

    assign cmd_ready = fifo_count != CNT_W'(DEPTH);
    assign fifo_push = cmd_valid & ~fifo_full;
    assign granted   = req & en & grant;
    assign last_beat = beats_left == '0;
    assign busy      = state != IDLE;
    // Pop in IDLE, or on the final granted beat so the next burst follows with no bubble
    assign fifo_pop  = ~fifo_empty & ((state == IDLE) | (granted & last_beat));

    arb_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wdata   ({cmd_len, cmd_data}),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            req        <= 1'b0;
            beats_left <= '0;
            idx        <= '0;
            base       <= '0;
            beat_valid <= 1'b0;
            beat_data  <= '0;
            beat_last  <= 1'b0;
        end else begin
            beat_valid <= 1'b0;
            beat_last  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        beats_left <= fifo_rdata[FIFO_W-1:DATA_W];
                        base       <= fifo_rdata[DATA_W-1:0];
                        idx        <= '0;
                        req        <= 1'b1;
                        state      <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (granted) begin
                        beat_valid <= 1'b1;
                        beat_data  <= base + DATA_W'(idx);
                        beat_last  <= last_beat;
                        if (!last_beat) begin
                            idx        <= idx + LEN_W'(1);
                            beats_left <= beats_left - LEN_W'(1);
                        end else if (!fifo_empty) begin
                            beats_left <= fifo_rdata[FIFO_W-1:DATA_W];
                            base       <= fifo_rdata[DATA_W-1:0];
                            idx        <= '0;
                        end else begin
                            req   <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    req   <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Monitors: both flags are sticky until reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en         <= 1'b0;
            starve_cnt <= '0;
            starve     <= 1'b0;
            err        <= 1'b0;
        end else begin
            en <= ~pause;
            if (!req || granted) begin
                starve_cnt <= '0;
            end else if (starve_cnt != STV_W'(STARVE)) begin
                starve_cnt <= starve_cnt + STV_W'(1);
                if (starve_cnt == STV_W'(STARVE - 1)) begin
                    starve <= 1'b1;
                end
            end
            if (grant && (!req || !en)) begin
                err <= 1'b1;
            end
        end
    end

endmodule
